// File: rtl/bky_multi_shift.sv
// ---------------------------------------------------------------------------
// bky_multi_shift
//
// Serial loader for a group of Buckeye chips. A start pulse latches a
// chip-select mask. Each selected chip is then shifted in ascending index
// order. Every chip receives BITS_PER_CHIP bits, LSB first, taken from
// DW-bit words that arrive on a valid/ready handshake. Each bit uses
// CLK_DIV cycles with bky_clk low, then CLK_DIV cycles with bky_clk high.
// Only the active chip sees bky_clk and to_bky activity.
//
// Optional feature (macro BKY_READBACK_EN):
//   When defined, the design samples bky_rtn of the active chip in the last
//   high cycle of every bit. It packs these samples LSB first into DW-bit
//   words on dout, and qualifies each word with a single-cycle dout_vld
//   strobe. When undefined, dout and dout_vld are tied to 0 and bky_rtn is
//   ignored.
//
// Ports:
//   clk20     in   1       sole clock, rising edge
//   sys_rst   in   1       synchronous active-high reset
//   start     in   1       pulse that begins a shift sequence (ignored if busy)
//   mask      in   N_CHIP  chip-select mask, latched when start is accepted
//   din       in   DW      word to shift out, LSB first
//   din_vld   in   1       din holds a valid word
//   din_rdy   out  1       word accepted when din_vld && din_rdy
//   to_bky    out  N_CHIP  serial data to each chip
//   bky_clk   out  N_CHIP  shift clock to each chip
//   bky_rtn   in   N_CHIP  serial return from each chip
//   dout      out  DW      readback word
//   dout_vld  out  1       one-cycle strobe qualifying dout
//   busy      out  1       sequence in progress
//   done      out  1       one-cycle pulse at sequence end
// ---------------------------------------------------------------------------
module bky_multi_shift #(
  parameter int N_CHIP        = 6,
  parameter int BITS_PER_CHIP = 48,
  parameter int DW            = 16,
  parameter int CLK_DIV       = 2
) (
  input  logic              clk20,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [N_CHIP-1:0] mask,
  input  logic [DW-1:0]     din,
  input  logic              din_vld,
  output logic              din_rdy,
  output logic [N_CHIP-1:0] to_bky,
  output logic [N_CHIP-1:0] bky_clk,
  input  logic [N_CHIP-1:0] bky_rtn,
  output logic [DW-1:0]     dout,
  output logic              dout_vld,
  output logic              busy,
  output logic              done
);

  localparam int WPC = BITS_PER_CHIP / DW;
  localparam int CW  = (N_CHIP > 1) ? $clog2(N_CHIP) : 1;
  localparam int WCW = (WPC > 1) ? $clog2(WPC) : 1;
  localparam int BW  = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [3:0]     DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST  = BW'(DW - 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(WPC - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOW,
    HIGH,
    NEXT,
    FIN
  } state_t;

  state_t            state_q, state_d;
  logic [N_CHIP-1:0] mask_q, mask_d;
  logic [CW-1:0]     chip_q, chip_d;
  logic [WCW-1:0]    wcnt_q, wcnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [3:0]        div_q, div_d;
  logic [DW-1:0]     word_q, word_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [N_CHIP-1:0] to_bky_q, to_bky_d;
  logic [N_CHIP-1:0] bky_clk_q, bky_clk_d;

  logic              firstFound;
  logic [CW-1:0]     firstIdx;
  logic              nextFound;
  logic [CW-1:0]     nextIdx;
  logic              bitEnd;

  // Find the lowest set bit of the incoming mask, which gives the first chip
  // of a new sequence. Also find the lowest latched mask bit above the
  // current chip, which gives the chip that follows in ascending order.
  // Both loops scan from the top down so that the last match, the lowest
  // index, wins.
  always_comb begin
    firstFound = 1'b0;
    firstIdx   = '0;
    nextFound  = 1'b0;
    nextIdx    = '0;
    for (int i = N_CHIP - 1; i >= 0; i--) begin
      if (mask[i]) begin
        firstFound = 1'b1;
        firstIdx   = CW'(i);
      end
      if (mask_q[i] && (i > int'(chip_q))) begin
        nextFound = 1'b1;
        nextIdx   = CW'(i);
      end
    end
  end

  // The last cycle of the high phase finishes a bit. The next-state logic
  // uses this signal, and so does the readback sampler.
  assign bitEnd = (state_q == HIGH) && (div_q == DIV_LAST);

  // Sequencer next-state logic. FETCH waits for a word. LOW and HIGH each
  // last CLK_DIV cycles per bit. At the end of a bit the machine moves to
  // the next bit, to the next word, or to the next chip. The pin values are
  // computed from the next state, so the registered pins line up exactly
  // with the state register and never glitch.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    chip_d    = chip_q;
    wcnt_d    = wcnt_q;
    bit_d     = bit_q;
    div_d     = div_q;
    word_d    = word_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    to_bky_d  = '0;
    bky_clk_d = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d = mask;
          busy_d = 1'b1;
          if (firstFound) begin
            chip_d  = firstIdx;
            wcnt_d  = '0;
            state_d = FETCH;
          end else begin
            state_d = FIN;
          end
        end
      end
      FETCH: begin
        if (din_vld) begin
          word_d  = din;
          bit_d   = '0;
          div_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      HIGH: begin
        if (bitEnd) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            if (wcnt_q == WCNT_LAST) begin
              state_d = NEXT;
            end else begin
              wcnt_d  = wcnt_q + 1'b1;
              state_d = FETCH;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          div_d = div_q + 4'd1;
        end
      end
      NEXT: begin
        if (nextFound) begin
          chip_d  = nextIdx;
          wcnt_d  = '0;
          state_d = FETCH;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_d == LOW) || (state_d == HIGH)) begin
      to_bky_d[chip_d] = word_d[bit_d];
    end
    if (state_d == HIGH) begin
      bky_clk_d[chip_d] = 1'b1;
    end
  end

  // State and output registers. Reset returns the machine to IDLE with
  // every pin low. A chip that was partly shifted keeps what it already
  // received, and no done pulse is produced for the aborted sequence.
  always_ff @(posedge clk20) begin
    if (sys_rst) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      chip_q    <= '0;
      wcnt_q    <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      word_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_bky_q  <= '0;
      bky_clk_q <= '0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      chip_q    <= chip_d;
      wcnt_q    <= wcnt_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      word_q    <= word_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_bky_q  <= to_bky_d;
      bky_clk_q <= bky_clk_d;
    end
  end

  assign din_rdy = (state_q == FETCH);
  assign to_bky  = to_bky_q;
  assign bky_clk = bky_clk_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef BKY_READBACK_EN
  logic [DW-1:0] rtn_q, rtn_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dout_vld_q, dout_vld_d;

  // Readback packing. New samples enter at the MSB and shift toward the
  // LSB, so after DW samples the first sample sits in bit 0. The word is
  // published together with its final sample and is not held for a
  // consumer.
  always_comb begin
    rtn_d      = rtn_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;
    if (bitEnd) begin
      rtn_d = {bky_rtn[chip_q], rtn_q[DW-1:1]};
      if (bit_q == BIT_LAST) begin
        dout_d     = rtn_d;
        dout_vld_d = 1'b1;
      end
    end
  end

  // Readback registers, cleared by reset like the rest of the datapath.
  always_ff @(posedge clk20) begin
    if (sys_rst) begin
      rtn_q      <= '0;
      dout_q     <= '0;
      dout_vld_q <= 1'b0;
    end else begin
      rtn_q      <= rtn_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign dout     = dout_q;
  assign dout_vld = dout_vld_q;
`else
  logic unused_rtn;
  assign unused_rtn = ^bky_rtn;
  assign dout       = '0;
  assign dout_vld   = 1'b0;
`endif

endmodule

// File: tb/tb_bky_multi_shift.sv
// ---------------------------------------------------------------------------
// tb_bky_multi_shift
//
// Directed bench for bky_multi_shift at default parameters (6 chips, 48 bits
// per chip, 16-bit words, CLK_DIV = 2). Each chip is modelled as a 48-bit
// shift register. The register takes to_bky on the rising edge of its
// bky_clk, loading from the MSB side. It returns the bit it shifts out on
// bky_rtn. Readback checks are enabled when BKY_READBACK_EN is defined.
// ---------------------------------------------------------------------------
module tb_bky_multi_shift;

  logic        clk20 = 1'b0;
  logic        sys_rst;
  logic        start;
  logic [5:0]  mask;
  logic [15:0] din;
  logic        din_vld;
  logic        din_rdy;
  logic [5:0]  to_bky;
  logic [5:0]  bky_clk;
  logic [5:0]  bky_rtn;
  logic [15:0] dout;
  logic        dout_vld;
  logic        busy;
  logic        done;

  bky_multi_shift dut (
    .clk20    (clk20),
    .sys_rst  (sys_rst),
    .start    (start),
    .mask     (mask),
    .din      (din),
    .din_vld  (din_vld),
    .din_rdy  (din_rdy),
    .to_bky   (to_bky),
    .bky_clk  (bky_clk),
    .bky_rtn  (bky_rtn),
    .dout     (dout),
    .dout_vld (dout_vld),
    .busy     (busy),
    .done     (done)
  );

  // 100 MHz-style free-running clock; only relative timing matters here.
  always #5 clk20 = ~clk20;

  int checkCount = 0;
  int errorCount = 0;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Chip models and run statistics, all owned by the monitor below.
  logic [47:0] model[6];
  logic [47:0] preloadVal[6];
  int          edges[6];
  int          edgeTotal;
  int          doneCnt;
  int          busyCnt;
  int          rdyCnt;
  int          strobeCnt;
  int          stallCnt;
  logic        stallClkBad;
  logic [5:0]  strayBits;
  logic [5:0]  prevClk = '0;
  logic [5:0]  rtnReg = '0;
  logic [15:0] rxWords[8];
  logic        loadReq = 1'b0;
  logic [5:0]  curMask = '0;
  logic [15:0] txWords[18];

  assign bky_rtn = rtnReg;

  // Monitor: runs on the falling edge so every DUT output is stable. A
  // rising bky_clk shifts the chip model and presents the outgoing bit on
  // bky_rtn. loadReq reloads the models and clears all statistics.
  always @(negedge clk20) begin
    if (loadReq) begin
      for (int i = 0; i < 6; i++) begin
        model[i] <= preloadVal[i];
        edges[i] <= 0;
      end
      rtnReg      <= '0;
      edgeTotal   <= 0;
      doneCnt     <= 0;
      busyCnt     <= 0;
      rdyCnt      <= 0;
      strobeCnt   <= 0;
      stallCnt    <= 0;
      stallClkBad <= 1'b0;
      strayBits   <= '0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (bky_clk[i] && !prevClk[i]) begin
          model[i]  <= {to_bky[i], model[i][47:1]};
          rtnReg[i] <= model[i][0];
          edges[i]  <= edges[i] + 1;
        end
      end
      edgeTotal <= edgeTotal + $countones(bky_clk & ~prevClk);
      if (done) doneCnt <= doneCnt + 1;
      if (busy) busyCnt <= busyCnt + 1;
      if (din_rdy) rdyCnt <= rdyCnt + 1;
      if (din_rdy && !din_vld) begin
        stallCnt <= stallCnt + 1;
        if (bky_clk != 6'd0) stallClkBad <= 1'b1;
      end
      if (dout_vld) begin
        if (strobeCnt < 8) rxWords[strobeCnt] <= dout;
        strobeCnt <= strobeCnt + 1;
      end
      strayBits <= strayBits | ((to_bky | bky_clk) & ~curMask);
    end
    prevClk <= bky_clk;
  end

  // Reload chip models from preloadVal and zero the statistics.
  task automatic clearModels();
    @(posedge clk20); #1;
    loadReq = 1'b1;
    @(posedge clk20); #1;
    loadReq = 1'b0;
  endtask

  // Starts a sequence and feeds txWords until done is seen. stallAt holds
  // din_vld low for stallLen FETCH cycles before word stallAt; mid-stall a
  // stray start with a full mask is also pulsed. abortEdges > 0 returns as
  // soon as that many bky_clk rising edges have been seen.
  task automatic applyStimulus(input logic [5:0] m, input int nWords,
                               input int stallAt, input int stallLen,
                               input int abortEdges, input int maxCycles,
                               output bit timedOut);
    int idx;
    int stallDone;
    int cyc;
    bit hs;
    bit stalling;
    bit glitched;
    idx       = 0;
    stallDone = 0;
    cyc       = 0;
    glitched  = 0;
    timedOut  = 0;
    curMask   = m;
    @(posedge clk20); #1;
    mask     = m;
    start    = 1'b1;
    stalling = (stallAt == 0) && (stallLen > 0);
    din_vld  = (nWords > 0) && !stalling;
    din      = txWords[0];
    @(posedge clk20); #1;
    start = 1'b0;
    while (1) begin
      @(negedge clk20);
      if (doneCnt > 0) break;
      if ((abortEdges > 0) && (edgeTotal >= abortEdges)) break;
      cyc++;
      if (cyc > maxCycles) begin
        timedOut = 1;
        break;
      end
      hs = din_vld && din_rdy;
      if (stalling && din_rdy && !din_vld) stallDone++;
      @(posedge clk20); #1;
      start = 1'b0;
      if (hs) idx++;
      stalling = (idx == stallAt) && (stallDone < stallLen);
      if (stalling && (stallDone == 5) && !glitched) begin
        start    = 1'b1;
        mask     = 6'h3F;
        glitched = 1;
      end
      din_vld = (idx < nWords) && !stalling;
      din     = (idx < nWords) ? txWords[idx] : 16'h0;
    end
    start   = 1'b0;
    din_vld = 1'b0;
  endtask

  bit to;

  initial begin
    sys_rst = 1'b1;
    start   = 1'b0;
    mask    = '0;
    din     = '0;
    din_vld = 1'b0;
    for (int i = 0; i < 6; i++) preloadVal[i] = '0;
    for (int k = 0; k < 18; k++) txWords[k] = 16'h0;

    repeat (3) @(posedge clk20);
    @(negedge clk20);
    checkOutput("reset_outputs",
                64'({to_bky, bky_clk, din_rdy, dout, dout_vld, busy, done}), 64'd0);
    @(posedge clk20); #1;
    sys_rst = 1'b0;

    // Single chip: only chip 3 sees edges; image is the three words, first word lowest.
    txWords[0] = 16'h9AE1; txWords[1] = 16'hD2BC; txWords[2] = 16'h3F78;
    clearModels();
    applyStimulus(6'b001000, 3, -1, 0, 0, 2000, to);
    checkOutput("t1_timeout", 64'(to), 64'd0);
    checkOutput("t1_chip3", 64'(model[3]), 64'h3F78D2BC9AE1);
    checkOutput("t1_edges3", 64'(edges[3]), 64'd48);
    checkOutput("t1_edgeTotal", 64'(edgeTotal), 64'd48);
    checkOutput("t1_stray", 64'(strayBits), 64'd0);
    checkOutput("t1_done", 64'(doneCnt), 64'd1);
    // 48 bits x 4 cycles + 3 fetches + 1 NEXT + 1 FIN
    checkOutput("t1_busy", 64'(busyCnt), 64'(48*4 + 3 + 1 + 1));

    // All chips: 18 words, three per chip in ascending chip order.
    for (int k = 0; k < 18; k++) txWords[k] = 16'(16'hC35A ^ (k * 16'h1357));
    clearModels();
    applyStimulus(6'b111111, 18, -1, 0, 0, 3000, to);
    checkOutput("t2_timeout", 64'(to), 64'd0);
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("t2_chip%0d", i), 64'(model[i]),
                  64'({txWords[3*i+2], txWords[3*i+1], txWords[3*i]}));
    checkOutput("t2_edgeTotal", 64'(edgeTotal), 64'd288);
    checkOutput("t2_done", 64'(doneCnt), 64'd1);
    // 288 bits x 4 cycles + 18 fetches + 6 NEXT + 1 FIN
    checkOutput("t2_busy", 64'(busyCnt), 64'(288*4 + 18 + 6 + 1));

    // Readback: chip 2 preloaded with 1111..., zeros shifted in.
    for (int k = 0; k < 3; k++) txWords[k] = 16'h0;
    preloadVal[2] = 48'h111111111111;
    clearModels();
    preloadVal[2] = 48'h0;
    applyStimulus(6'b000100, 3, -1, 0, 0, 2000, to);
    checkOutput("t3_timeout", 64'(to), 64'd0);
    checkOutput("t3_chip2", 64'(model[2]), 64'd0);
`ifdef BKY_READBACK_EN
    checkOutput("t3_strobes", 64'(strobeCnt), 64'd3);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("t3_rx%0d", k), 64'(rxWords[k]), 64'h1111);
`else
    checkOutput("t3_strobes", 64'(strobeCnt), 64'd0);
    checkOutput("t3_dout", 64'(dout), 64'd0);
`endif

    // Stall of 10 FETCH cycles before word 1, with a stray start/mask mid-stall.
    txWords[0] = 16'h5A0F; txWords[1] = 16'hC3E7; txWords[2] = 16'h0B1D;
    clearModels();
    applyStimulus(6'b010000, 3, 1, 10, 0, 2000, to);
    checkOutput("t4_timeout", 64'(to), 64'd0);
    checkOutput("t4_stallCnt", 64'(stallCnt), 64'd10);
    checkOutput("t4_stallClk", 64'(stallClkBad), 64'd0);
    checkOutput("t4_chip4", 64'(model[4]), 64'h0B1DC3E75A0F);
    checkOutput("t4_edgeTotal", 64'(edgeTotal), 64'd48);
    checkOutput("t4_stray", 64'(strayBits), 64'd0);
    checkOutput("t4_done", 64'(doneCnt), 64'd1);
    checkOutput("t4_busy", 64'(busyCnt), 64'(48*4 + 3 + 1 + 1 + 10));

    // Empty mask: FIN one cycle later, done the cycle after that.
    clearModels();
    curMask = 6'd0;
    @(posedge clk20); #1;
    mask  = 6'd0;
    start = 1'b1;
    @(posedge clk20); #1;
    start = 1'b0;
    @(negedge clk20);
    checkOutput("t5_done_early", 64'(done), 64'd0);
    checkOutput("t5_busy_fin", 64'(busy), 64'd1);
    @(negedge clk20);
    checkOutput("t5_done", 64'(done), 64'd1);
    checkOutput("t5_busy_drop", 64'(busy), 64'd0);
    repeat (3) @(negedge clk20);
    checkOutput("t5_rdy", 64'(rdyCnt), 64'd0);
    checkOutput("t5_edges", 64'(edgeTotal), 64'd0);
    checkOutput("t5_doneCnt", 64'(doneCnt), 64'd1);

    // Reset after 20 bits of chip 0, then a clean run on chip 1.
    txWords[0] = 16'hFFFF; txWords[1] = 16'hA5A5; txWords[2] = 16'h0F0F;
    clearModels();
    applyStimulus(6'b000001, 3, -1, 0, 20, 2000, to);
    checkOutput("t6_abort_timeout", 64'(to), 64'd0);
    sys_rst = 1'b1;
    @(posedge clk20); #1;
    checkOutput("t6_rst_outputs",
                64'({to_bky, bky_clk, din_rdy, dout, dout_vld, busy, done}), 64'd0);
    sys_rst = 1'b0;
    repeat (8) @(negedge clk20);
    checkOutput("t6_no_done", 64'(doneCnt), 64'd0);
    checkOutput("t6_edges0", 64'(edges[0]), 64'd20);
    checkOutput("t6_idle_busy", 64'(busy), 64'd0);
    txWords[0] = 16'h1234; txWords[1] = 16'h5678; txWords[2] = 16'h9ABC;
    clearModels();
    applyStimulus(6'b000010, 3, -1, 0, 0, 2000, to);
    checkOutput("t6_rerun_timeout", 64'(to), 64'd0);
    checkOutput("t6_chip1", 64'(model[1]), 64'h9ABC56781234);
    checkOutput("t6_done", 64'(doneCnt), 64'd1);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
